// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
// Optional feature macro: DIV_ZERO_EARLY_EN (divide-by-zero completes one cycle after start).
module ex_muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  input  logic              d_stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nx;
  logic [2:0]          op_q;
  logic                neg_res, neg_rem, div_zero;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc;
  logic [4:0]          count;
  logic [DATA_W-1:0]   result_q;

  logic                s1_signed, s2_signed, neg1, neg2, zero_in, start_ok, early;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     mul_sum, div_trial;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] mul_next, div_next, acc_next, prod_s;
  logic [DATA_W-1:0]   quot_s, rem_s, fix_val;

  // Absolute values are taken only where op treats the operand as signed.
  always_comb begin
    s1_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    s2_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    neg1      = s1_signed & src1[DATA_W-1];
    neg2      = s2_signed & src2[DATA_W-1];
    abs1      = neg1 ? -src1 : src1;
    abs2      = neg2 ? -src2 : src2;
    zero_in   = (src2 == '0);
    start_ok  = start & ~flush;
`ifdef DIV_ZERO_EARLY_EN
    early     = op[2] & zero_in;
`else
    early     = 1'b0;
`endif
  end

  // Multiply keeps the multiplier in acc low half and shifts right; divide shifts {rem,quot} left.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[DATA_W-1:1]};
    div_trial = acc[2*DATA_W-1:DATA_W-1];
    div_ge    = div_trial >= {1'b0, opnd};
    div_diff  = div_trial[DATA_W-1:0] - opnd;
    div_next  = {(div_ge ? div_diff : div_trial[DATA_W-1:0]), acc[DATA_W-2:0], div_ge};
    acc_next  = op_q[2] ? div_next : mul_next;
  end

  always_comb begin
    prod_s  = neg_res ? -acc : acc;
    quot_s  = div_zero ? '1 : (neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
    rem_s   = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    fix_val = '0;
    if (op_q[2])
      fix_val = op_q[1] ? rem_s : quot_s;
    else
      fix_val = (op_q[1:0] == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = early ? DONE : CALC;
      CALC:    if (count == 5'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (!d_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          op_q     <= op;
          neg_res  <= neg1 ^ neg2;
          neg_rem  <= neg1;
          div_zero <= zero_in;
          opnd     <= op[2] ? abs2 : abs1;
          acc      <= {{DATA_W{1'b0}}, (op[2] ? abs1 : abs2)};
          count    <= '0;
`ifdef DIV_ZERO_EARLY_EN
          if (early) result_q <= op[1] ? src1 : '1;
`endif
        end
        CALC: if (!flush) begin
          acc <= acc_next;
          if (count != 5'd31) count <= count + 5'd1;
        end
        FIX: if (!flush) result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign busy   = ~rst & (((state == IDLE) & start_ok) | (state == CALC) | (state == FIX));
  assign done   = (state == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - scoreboard bench for ex_muldiv_seq
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush, d_stall;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic        done_q = 1'b0;

`ifdef DIV_ZERO_EARLY_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
    string       nm;
  } vec_t;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .d_stall(d_stall), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: one result check per rising edge of done.
  always @(negedge clk) begin
    if (!rst && done && !done_q) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: result %h with no op pending, expected no done", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
    done_q <= done;
  end

  task automatic wait_done(output int n, output int bc);
    bit got;
    n = 0; bc = 0; got = 0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      else if (busy) bc++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int n, bc;
    @(posedge clk); #1;
    op = v.o; src1 = v.a; src2 = v.b; start = 1'b1;
    exp_q.push_back(v.e);
    @(negedge clk);
    chk({v.nm, "_busy_t0"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, bc);
    chk({v.nm, "_latency"}, 32'(n), 32'(v.lat));
    chk({v.nm, "_busy_cycles"}, 32'(bc), 32'(v.lat - 1));
    chk({v.nm, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk({v.nm, "_idle_after"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    int   n, bc;
    tbl[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34,   "mul"};
    tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34,   "mulh"};
    tbl[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34,   "mulhu"};
    tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34,   "mulhsu"};
    tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34,   "div"};
    tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34,   "rem"};
    tbl[6]  = '{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34,   "divu"};
    tbl[7]  = '{3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, ZLAT, "div_by0"};
    tbl[8]  = '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, ZLAT, "remu_by0"};
    tbl[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34,   "div_ovf"};
    tbl[10] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34,   "rem_ovf"};

    rst = 1'b1; start = 1'b1; flush = 1'b0; d_stall = 1'b0;
    op = 3'b000; src1 = 32'd1; src2 = 32'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(tbl[i]);

    // Flushed op: no push, so any done would be flagged by the monitor.
    @(posedge clk); #1;
    op = 3'b000; src1 = 32'd3; src2 = 32'd5; start = 1'b1;
    @(negedge clk);
    chk("flush_busy_t0", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_t10", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_t11_idle", {30'b0, done, busy}, 32'd0);
    run_op('{3'b000, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush"});

    // d_stall extends DONE; start held high there must not restart the op.
    @(posedge clk); #1;
    op = 3'b000; src1 = 32'h00000007; src2 = 32'hFFFFFFFD; start = 1'b1;
    exp_q.push_back(32'hFFFFFFEB);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, bc);
    chk("stall_latency", 32'(n), 32'd34);
    d_stall = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("stall_done_t%0d", 35 + k), {31'b0, done}, 32'd1);
      chk($sformatf("stall_result_t%0d", 35 + k), result, 32'hFFFFFFEB);
      chk($sformatf("stall_busy_t%0d", 35 + k), {31'b0, busy}, 32'd0);
    end
    d_stall = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("stall_exit_idle", {30'b0, done, busy}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer for the EX stage of the 5-stage RV32 pipeline, implementing the M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It latches forwarded operands when an M-type instruction reaches EX and runs a 32-iteration shift-add or restoring-divide datapath. It raises a stall request to the hazard logic until the result is ready, then presents the result for capture by the EX/MEM register. It cooperates with the existing `d_stall` and EX flush signals.

## Interface
- DATA_W, 32, operand/result width (only 32 is supported)
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  M-type instruction valid in EX (ID/EX not flushed)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  in  DATA_W  rs1 value after forwarding
- src2  in  DATA_W  rs2 value after forwarding
- flush  in  1  kill the in-flight op (branch/jump redirect)
- d_stall  in  1  D-cache stall; holds the pipeline
- busy  out  1  stall request to IF/ID/EX; combinational
- done  out  1  result valid; registered state decode
- result  out  DATA_W  final result; stable while done=1

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on start=1 and flush=0, latch op, sign flags, |src1| and |src2|; absolute value is taken only for signed operands. Clear count and go to CALC.
- CALC: one iteration per cycle. After iteration 31 (count==31), go to FIX.
  - Multiply: 64-bit shift-add into the product register.
  - Divide: restoring step on a {rem,quot} 64-bit register.
- FIX: sign correction and op select, written into result. Then go to DONE.
  - MUL returns the low 32 bits. MULH/MULHSU/MULHU return the high 32 bits. The product is negated when operand signs differ, under the signedness given by op.
  - DIV: quotient is negated if signs differ. REM: remainder takes the sign of the dividend.
  - Divide by zero: quotient 0xFFFFFFFF for both signed and unsigned; remainder = src1.
  - Overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- DONE: done=1. start is ignored. Go to IDLE at the first edge with d_stall=0; the EX/MEM register captures result at that same edge.
- busy = (IDLE & start & ~flush) | CALC | FIX. busy is 0 in DONE.
- flush=1 in any state: go to IDLE at the next edge; done is not asserted and result is not updated. flush has priority over start.
- Reset: state IDLE, count 0, result 0, done 0. busy is forced to 0 while rst=1.

## Timing
- T0: start is seen in IDLE; busy=1 in the same cycle.
- T1–T32: CALC, busy=1.
- T33: FIX, busy=1.
- T34: DONE, done=1, busy=0.
- Worst-case latency: 34 cycles from start to done. busy is high for cycles T0–T33.
- d_stall high in DONE extends DONE. result and done are held unchanged.
- Back-to-back ops: the next M-type op reaches EX at T35 at the earliest and starts from IDLE. There is no start-to-start hazard.
- Reset asserted mid-operation: the block asynchronously enters IDLE; partial state is discarded.
- count is 5 bits and does not wrap; it exits at 31.

## Configuration
- DIV_ZERO_EARLY_EN defined: a DIV/DIVU/REM/REMU with src2==0 seen in IDLE goes directly to DONE at the next edge.
  - result = 0xFFFFFFFF (DIV/DIVU) or src1 (REM/REMU).
  - busy is high only at T0; done at T1.
- Not defined: divide by zero takes the full 34-cycle path and gives identical result values.
- All other ops are unaffected.

## Test plan
- MUL src1=7, src2=0xFFFFFFFD: busy=1 for T0–T33; done at T34 with result=0xFFFFFFEB. Returns to IDLE at T35 with d_stall=0.
- MULH 0x80000000×0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC.
- DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - Done at T34 without DIV_ZERO_EARLY_EN; the divide-by-zero cases finish at T1 with it.
- flush at T10: IDLE at T11 with busy=0 and no done pulse. A new MUL 3×4 started at T12 gives done at T46 with result=12.
- d_stall=1 during T34–T36: done=1 and result held constant through T36. IDLE at the T37 edge. start held high in DONE does not restart the op.
